// File: rtl/sysid_regs_pkg.sv
// Shared constants and types for the pipelined system-ID register block.
// Offsets are word addresses on the Avalon-MM slave.
package sysid_regs_pkg;

   localparam int unsigned SYSID_ADDR_ID        = 0;
   localparam int unsigned SYSID_ADDR_TIMESTAMP = 1;
   localparam int unsigned SYSID_ADDR_VERSION   = 2;
   localparam int unsigned SYSID_ADDR_SCRATCH   = 3;
   localparam int unsigned SYSID_ADDR_UPTIME_LO = 4;
   localparam int unsigned SYSID_ADDR_UPTIME_HI = 5;
   localparam int unsigned SYSID_ADDR_CTRL      = 6;

   localparam int unsigned CTRL_CLEAR_BIT  = 0;
   localparam int unsigned CTRL_FREEZE_BIT = 1;

   localparam int unsigned READ_LATENCY_MIN = 1;
   localparam int unsigned READ_LATENCY_MAX = 4;
   localparam int unsigned ADDR_W_MIN       = 3;
   localparam int unsigned ADDR_W_MAX       = 8;

   typedef struct packed {
      logic        valid;
      logic [31:0] data;
   } rd_stage_t;

endpackage

// File: rtl/sysid_uptime_counter.sv
// 64-bit free-running uptime counter with clear/freeze and a latched copy of
// the upper word, captured when the low word is read.
module sysid_uptime_counter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        freeze_i,
   input  logic        snapshot_en_i,
   output logic [63:0] count_o,
   output logic [31:0] snapshot_hi_o
);

   logic [63:0] count_d, count_q;
   logic [31:0] snap_d, snap_q;

   // Clear wins over both freeze and increment.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (!freeze_i) begin
         count_d = count_q + 64'd1;
      end
      snap_d = snapshot_en_i ? count_q[63:32] : snap_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         snap_q  <= '0;
      end else begin
         count_q <= count_d;
         snap_q  <= snap_d;
      end
   end

   assign count_o       = count_q;
   assign snapshot_hi_o = snap_q;

endmodule

// File: rtl/sysid_regs_pipelined.sv
// Avalon-MM system-ID register block: ID/timestamp/version, scratch, uptime
// with coherent high-word snapshot, and control; fixed-latency read pipeline.
module sysid_regs_pipelined
   import sysid_regs_pkg::*;
#(
   parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
   parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
   parameter logic [31:0] VERSION       = 32'h0001_0000,
   parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000,
   parameter int unsigned ADDR_W        = 3,
   parameter int unsigned READ_LATENCY  = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address,
   input  logic              read,
   input  logic              write,
   input  logic [31:0]       writedata,
   input  logic [3:0]        byteenable,
   output logic [31:0]       readdata,
   output logic              readdatavalid
);

   if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : gen_bad_lat
      $error("sysid_regs_pipelined: READ_LATENCY out of range");
   end
   if (ADDR_W < ADDR_W_MIN || ADDR_W > ADDR_W_MAX) begin : gen_bad_addr_w
      $error("sysid_regs_pipelined: ADDR_W out of range");
   end

   logic [7:0]  addr_ext;
   logic        sel_scratch, sel_ctrl, sel_uptime_lo;
   logic        wr_scratch, wr_ctrl, rd_accept;
   logic        clear, snapshot_en;
   logic [31:0] scratch_d, scratch_q;
   logic        freeze_d, freeze_q;
   logic [31:0] rd_data;
   logic [63:0] uptime;
   logic [31:0] snapshot_hi;
   rd_stage_t   pipe_d [READ_LATENCY];
   rd_stage_t   pipe_q [READ_LATENCY];

   // Zero-extend so addresses >= 8 never alias onto a real register.
   always_comb begin
      addr_ext              = '0;
      addr_ext[ADDR_W-1:0]  = address;
   end

   assign sel_scratch   = (addr_ext == 8'(SYSID_ADDR_SCRATCH));
   assign sel_ctrl      = (addr_ext == 8'(SYSID_ADDR_CTRL));
   assign sel_uptime_lo = (addr_ext == 8'(SYSID_ADDR_UPTIME_LO));

   assign wr_scratch  = write & sel_scratch;
   assign wr_ctrl     = write & sel_ctrl & byteenable[0];
   // A scratch read colliding with a scratch write is dropped; the write wins.
   assign rd_accept   = read & ~wr_scratch;
   assign clear       = wr_ctrl & writedata[CTRL_CLEAR_BIT];
   assign snapshot_en = rd_accept & sel_uptime_lo;

   always_comb begin
      scratch_d = scratch_q;
      if (wr_scratch) begin
         for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
               scratch_d[8*b +: 8] = writedata[8*b +: 8];
            end
         end
      end
      freeze_d = wr_ctrl ? writedata[CTRL_FREEZE_BIT] : freeze_q;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         scratch_q <= SCRATCH_RESET;
         freeze_q  <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         freeze_q  <= freeze_d;
      end
   end

   sysid_uptime_counter u_uptime (
      .clk_i         (clock),
      .rst_ni        (reset_n),
      .clear_i       (clear),
      .freeze_i      (freeze_q),
      .snapshot_en_i (snapshot_en),
      .count_o       (uptime),
      .snapshot_hi_o (snapshot_hi)
   );

   logic unused_uptime_hi;
   assign unused_uptime_hi = ^uptime[63:32];

   always_comb begin
      rd_data = '0;
      case (addr_ext)
         8'(SYSID_ADDR_ID):        rd_data = SYSTEM_ID;
         8'(SYSID_ADDR_TIMESTAMP): rd_data = TIMESTAMP;
         8'(SYSID_ADDR_VERSION):   rd_data = VERSION;
         8'(SYSID_ADDR_SCRATCH):   rd_data = scratch_q;
         8'(SYSID_ADDR_UPTIME_LO): rd_data = uptime[31:0];
         8'(SYSID_ADDR_UPTIME_HI): rd_data = snapshot_hi;
         8'(SYSID_ADDR_CTRL):      rd_data[CTRL_FREEZE_BIT] = freeze_q;
         default:                  rd_data = '0;
      endcase
   end

   // Non-accepted slots carry zero data so readdata is 0 whenever not valid.
   always_comb begin
      pipe_d[0].valid = rd_accept;
      pipe_d[0].data  = rd_accept ? rd_data : '0;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pipe_q <= '{default: '0};
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign readdatavalid = pipe_q[READ_LATENCY-1].valid;
   assign readdata      = pipe_q[READ_LATENCY-1].data;

endmodule
